// File: rtl/fir_out_stage.sv
// ---------------------------------------------------------------------------
// fir_out_stage
//
// Output conditioning for the time-multiplexed symmetric FIR core. Each
// strobed MAC result is processed in three steps:
//   1. Round half toward +inf and scale down by 2^SHIFT (stage-1 register).
//   2. Saturate to WIDTH_OUT bits (stage 2), which feeds the FIFO write.
//   3. Buffer in a DEPTH-entry first-word-fall-through FIFO, so the consumer
//      can drain samples at its own pace.
//
// Ports
//   clk        in   system clock, rising edge
//   rst        in   asynchronous active-low reset
//   din        in   signed MAC result (WIDTH_IN bits)
//   din_valid  in   one-cycle strobe qualifying din
//   dout       out  head-of-FIFO sample, signed (WIDTH_OUT bits)
//   dout_valid out  FIFO not empty
//   dout_ready in   consumer accepts dout this cycle
//   sat_flag   out  sticky: a sample has been saturated since reset
//   overflow   out  sticky: a sample has been dropped since reset
//   drop_cnt   out  count of dropped samples, saturates at 255
//
// Handshake: dout is transferred on every rising edge where dout_valid and
// dout_ready are both high. dout_valid never depends on dout_ready. The
// input side has no backpressure. A sample that arrives at a full FIFO is
// dropped, unless a read happens on the same edge.
// ---------------------------------------------------------------------------
module fir_out_stage #(
    parameter int WIDTH_IN   = 16,
    parameter int WIDTH_OUT  = 8,
    parameter int SHIFT      = 7,
    parameter int DEPTH      = 4,
    parameter int LOG2_DEPTH = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH_IN-1:0]  din,
    input  logic                 din_valid,
    output logic [WIDTH_OUT-1:0] dout,
    output logic                 dout_valid,
    input  logic                 dout_ready,
    output logic                 sat_flag,
    output logic                 overflow,
    output logic [7:0]           drop_cnt
);

    // Rounding constant 2^(SHIFT-1). Computing it as (1 << SHIFT) >> 1
    // gives 0 when SHIFT = 0, so no separate case is needed.
    localparam logic signed [WIDTH_IN:0] round_add =
        ((WIDTH_IN+1)'(1) << SHIFT) >> 1;

    localparam logic [LOG2_DEPTH:0] full_count = (LOG2_DEPTH+1)'(DEPTH);

    localparam logic [WIDTH_OUT-1:0] sat_pos = {1'b0, {(WIDTH_OUT-1){1'b1}}};
    localparam logic [WIDTH_OUT-1:0] sat_neg = {1'b1, {(WIDTH_OUT-1){1'b0}}};

    // ------------------------------------------------------------------
    // Stage 1: round and scale
    // ------------------------------------------------------------------
    // One extra bit of headroom, so that adding the rounding constant to the
    // most positive input cannot wrap.
    logic signed [WIDTH_IN:0] din_ext;
    logic signed [WIDTH_IN:0] rounded;
    logic signed [WIDTH_IN:0] scaled;

    logic signed [WIDTH_IN:0] s1_val;
    logic                     v1;

    always_comb begin
        din_ext = $signed({din[WIDTH_IN-1], din});
        rounded = din_ext + round_add;
        scaled  = rounded >>> SHIFT;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_val <= '0;
            v1     <= 1'b0;
        end else begin
            v1 <= din_valid;
            if (din_valid) begin
                s1_val <= scaled;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: saturate
    // ------------------------------------------------------------------
    // The value fits in WIDTH_OUT bits when all bits from the output sign
    // position upward are copies of the sign bit.
    logic [WIDTH_IN-WIDTH_OUT+1:0] s1_upper;
    logic                          s1_fits;
    logic [WIDTH_OUT-1:0]          s2_val;

    always_comb begin
        s1_upper = s1_val[WIDTH_IN:WIDTH_OUT-1];
        s1_fits  = (&s1_upper) | (~|s1_upper);
        if (s1_fits) begin
            s2_val = s1_val[WIDTH_OUT-1:0];
        end else if (s1_val[WIDTH_IN]) begin
            s2_val = sat_neg;
        end else begin
            s2_val = sat_pos;
        end
    end

    // ------------------------------------------------------------------
    // FIFO
    // ------------------------------------------------------------------
    logic [WIDTH_OUT-1:0]  mem [DEPTH];
    logic [LOG2_DEPTH-1:0] wr_ptr;
    logic [LOG2_DEPTH-1:0] rd_ptr;
    logic [LOG2_DEPTH:0]   count;

    logic full;
    logic rd_en;
    logic wr_en;
    logic drop;

    always_comb begin
        full       = (count == full_count);
        dout_valid = (count != '0);
        rd_en      = dout_valid && dout_ready;
        // A read on the same edge frees the slot, so a full FIFO still
        // takes the write in that case.
        wr_en      = v1 && (!full || rd_en);
        drop       = v1 && full && !rd_en;
        dout       = mem[rd_ptr];
    end

    // Storage is cleared on reset, so dout reads 0 right after reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            mem[wr_ptr] <= s2_val;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr_en, rd_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Status flags
    // ------------------------------------------------------------------
    // A sample that is clamped sets sat_flag even when that sample is
    // then dropped at a full FIFO.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sat_flag <= 1'b0;
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else begin
            if (v1 && !s1_fits) begin
                sat_flag <= 1'b1;
            end
            if (drop) begin
                overflow <= 1'b1;
                if (drop_cnt != 8'hFF) begin
                    drop_cnt <= drop_cnt + 8'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_fir_out_stage.sv
// ---------------------------------------------------------------------------
// tb_fir_out_stage
//
// Bench for fir_out_stage. Driver tasks present samples together with their
// expected output. A reference model runs on the falling edge. It tracks
// the pipeline stage, FIFO occupancy, drops and sticky flags. It compares
// the DUT state every cycle, and it checks each dout that is read out
// against the front of exp_q.
// ---------------------------------------------------------------------------
module tb_fir_out_stage;

    localparam int WIDTH_IN   = 16;
    localparam int WIDTH_OUT  = 8;
    localparam int SHIFT      = 7;
    localparam int DEPTH      = 4;
    localparam int LOG2_DEPTH = 2;

    logic                 clk;
    logic                 rst;
    logic [WIDTH_IN-1:0]  din;
    logic                 din_valid;
    logic [WIDTH_OUT-1:0] dout;
    logic                 dout_valid;
    logic                 dout_ready;
    logic                 sat_flag;
    logic                 overflow;
    logic [7:0]           drop_cnt;

    fir_out_stage #(
        .WIDTH_IN   (WIDTH_IN),
        .WIDTH_OUT  (WIDTH_OUT),
        .SHIFT      (SHIFT),
        .DEPTH      (DEPTH),
        .LOG2_DEPTH (LOG2_DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .din_valid  (din_valid),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .sat_flag   (sat_flag),
        .overflow   (overflow),
        .drop_cnt   (drop_cnt)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model / scoreboard ----------------
    logic [WIDTH_OUT-1:0] exp_q[$];
    logic [WIDTH_OUT-1:0] pend_val = '0;
    logic                 pend_sat = 1'b0;
    logic                 m_v1     = 1'b0;
    logic [WIDTH_OUT-1:0] m_v1_val = '0;
    logic                 m_v1_sat = 1'b0;
    logic                 m_sat    = 1'b0;
    logic                 m_ovf    = 1'b0;
    int                   m_drops  = 0;

    // Round half up, shift, clamp. Returns {saturated, value}.
    function automatic logic [WIDTH_OUT:0] ref_out(input logic [WIDTH_IN-1:0] d);
        int x;
        int lo;
        int hi;
        x  = int'($signed(d));
        x  = (x + ((1 << SHIFT) >> 1)) >>> SHIFT;
        hi = (1 << (WIDTH_OUT-1)) - 1;
        lo = -(1 << (WIDTH_OUT-1));
        if (x > hi) return {1'b1, WIDTH_OUT'(hi)};
        if (x < lo) return {1'b1, WIDTH_OUT'(lo)};
        return {1'b0, WIDTH_OUT'(x)};
    endfunction

    // Falling edge: check that the DUT matches the model, then advance the
    // model by the effect of the coming rising edge.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                exp_q.delete();
                m_v1    = 1'b0;
                m_sat   = 1'b0;
                m_ovf   = 1'b0;
                m_drops = 0;
            end else begin
                check("dout_valid", 32'(dout_valid), 32'(exp_q.size() != 0));
                check("count", 32'(dut.count), 32'(exp_q.size()));
                check("sat_flag", 32'(sat_flag), 32'(m_sat));
                check("overflow", 32'(overflow), 32'(m_ovf));
                check("drop_cnt", 32'(drop_cnt), 32'(m_drops));
                if (exp_q.size() != 0 && dout_ready) begin
                    check("dout", 32'(dout), 32'(exp_q.pop_front()));
                end
                if (m_v1) begin
                    if (m_v1_sat) m_sat = 1'b1;
                    if (exp_q.size() < DEPTH) begin
                        exp_q.push_back(m_v1_val);
                    end else begin
                        m_ovf = 1'b1;
                        if (m_drops != 255) m_drops++;
                    end
                end
                m_v1     = din_valid;
                m_v1_val = pend_val;
                m_v1_sat = pend_sat;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_sample(input logic [WIDTH_IN-1:0] d,
                                input logic [WIDTH_OUT-1:0] e,
                                input logic s);
        din       = d;
        din_valid = 1'b1;
        pend_val  = e;
        pend_sat  = s;
        next_cycle();
        din_valid = 1'b0;
    endtask

    task automatic drive_random(input logic [WIDTH_IN-1:0] d);
        logic [WIDTH_OUT:0] r;
        r = ref_out(d);
        drive_sample(d, r[WIDTH_OUT-1:0], r[WIDTH_OUT]);
    endtask

    task automatic drain(input string tag);
        int n;
        dout_ready = 1'b1;
        n = 0;
        while ((exp_q.size() != 0 || m_v1 || din_valid) && n < 30) begin
            next_cycle();
            n++;
        end
        if (n >= 30) check({tag, "_timeout"}, 32'(exp_q.size()), 32'd0);
        next_cycle();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst        = 1'b0;
        din        = '0;
        din_valid  = 1'b0;
        dout_ready = 1'b0;

        // Reset state
        repeat (2) next_cycle();
        check("rst_dout_valid", 32'(dout_valid), 32'd0);
        check("rst_dout", 32'(dout), 32'd0);
        check("rst_drop_cnt", 32'(drop_cnt), 32'd0);
        #1 rst = 1'b1;
        next_cycle();

        // Rounding, positive and negative
        dout_ready = 1'b1;
        drive_sample(16'h0140, 8'h03, 1'b0);
        next_cycle();
        check("lat_valid", 32'(dout_valid), 32'd1);
        check("lat_dout", 32'(dout), 32'h03);
        drive_sample(16'hFF40, 8'hFF, 1'b0);
        drive_sample(16'hFF3F, 8'hFE, 1'b0);
        drain("round");
        check("no_sat", 32'(sat_flag), 32'd0);

        // Saturation, then the sticky flag
        drive_sample(16'h7FFF, 8'h7F, 1'b1);
        drive_sample(16'h8000, 8'h80, 1'b1);
        drain("sat");
        drive_sample(16'h0140, 8'h03, 1'b0);
        drain("sat_sticky");
        check("sat_sticky", 32'(sat_flag), 32'd1);

        // Full and drop
        dout_ready = 1'b0;
        drive_sample(16'd128, 8'h01, 1'b0);
        drive_sample(16'd256, 8'h02, 1'b0);
        drive_sample(16'd384, 8'h03, 1'b0);
        drive_sample(16'd512, 8'h04, 1'b0);
        drive_sample(16'd640, 8'h05, 1'b0);
        repeat (2) next_cycle();
        check("full_count", 32'(dut.count), 32'd4);
        check("full_overflow", 32'(overflow), 32'd1);
        check("full_drop_cnt", 32'(drop_cnt), 32'd1);

        // Full with a read on the same edge as the write
        drive_sample(16'd768, 8'h06, 1'b0);
        dout_ready = 1'b1;
        next_cycle();
        dout_ready = 1'b0;
        next_cycle();
        check("fullrd_count", 32'(dut.count), 32'd4);
        check("fullrd_drop_cnt", 32'(drop_cnt), 32'd1);
        drain("full");
        check("drained_valid", 32'(dout_valid), 32'd0);

        // Random traffic
        for (int i = 0; i < 60; i++) begin
            dout_ready = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) != 0) begin
                drive_random(16'($urandom_range(0, 65535)));
            end else begin
                next_cycle();
            end
        end
        drain("rand");

        // Async reset mid-stream, while three entries are held
        dout_ready = 1'b0;
        drive_sample(16'd128, 8'h01, 1'b0);
        drive_sample(16'd256, 8'h02, 1'b0);
        drive_sample(16'h7FFF, 8'h7F, 1'b1);
        repeat (2) next_cycle();
        check("pre_rst_count", 32'(dut.count), 32'd3);
        #2 rst = 1'b0;
        #1;
        check("arst_dout_valid", 32'(dout_valid), 32'd0);
        check("arst_dout", 32'(dout), 32'd0);
        check("arst_sat", 32'(sat_flag), 32'd0);
        check("arst_overflow", 32'(overflow), 32'd0);
        check("arst_drop_cnt", 32'(drop_cnt), 32'd0);
        repeat (2) next_cycle();
        #2 rst = 1'b1;
        next_cycle();
        dout_ready = 1'b1;
        drive_sample(16'h0140, 8'h03, 1'b0);
        next_cycle();
        check("post_rst_valid", 32'(dout_valid), 32'd1);
        check("post_rst_dout", 32'(dout), 32'h03);
        drain("post_rst");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
